// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-through data cache (optional stats: DCACHE_STATS_EN)
module dcache_direct #(
    parameter int               WIDTH         = 32,
    parameter int               LINES         = 64,
    parameter int               MISS_CYCLES   = 2,
    parameter logic [WIDTH-1:0] UNCACHED_ADDR = 32'h100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [2:0]       modeAddr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] WD,
    input  logic             flush,
    output logic [WIDTH-1:0] RD,
    output logic             stall,
    output logic [2:0]       mem_modeAddr,
    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    output logic             mem_WE,
    input  logic [WIDTH-1:0] mem_RD
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = WIDTH - IDX - 2;
    localparam int CW   = $clog2(MISS_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MISS,
        S_FILL
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;

    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tag_mem  [LINES];
    logic [WIDTH-1:0] data_mem [LINES];

    logic [IDX-1:0]   idx;
    logic [TAGW-1:0]  tag_in;
    logic [WIDTH-1:0] line_word;
    logic             line_hit;

    logic mode_word, mode_half, mode_byte, mode_ok;
    logic misaligned, bypass, is_load, cache_load, cache_store;
    logic fill_en;

    logic [4:0]       byte_off;
    logic [4:0]       half_off;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [WIDTH-1:0] load_ext;
    logic [WIDTH-1:0] store_word;

    assign idx       = A[IDX+1:2];
    assign tag_in    = A[WIDTH-1:IDX+2];
    assign line_word = data_mem[idx];
    assign line_hit  = valid[idx] && (tag_mem[idx] == tag_in);

    // Signed and unsigned variants share the same lane width and alignment rule
    assign mode_word = (modeAddr == 3'b001);
    assign mode_half = (modeAddr == 3'b010) || (modeAddr == 3'b100);
    assign mode_byte = (modeAddr == 3'b011) || (modeAddr == 3'b101);
    assign mode_ok   = mode_word || mode_half || mode_byte;

    assign misaligned  = (mode_word && (A[1:0] != 2'b00)) || (mode_half && A[0]);
    assign bypass      = (A == UNCACHED_ADDR) || misaligned;
    assign is_load     = MemRead && !MemWrite;
    assign cache_load  = is_load && !bypass && mode_ok;
    assign cache_store = MemWrite && !bypass && mode_ok;

    assign byte_off = {A[1:0], 3'b000};
    assign half_off = {A[1], 4'b0000};
    assign sel_byte = line_word[byte_off +: 8];
    assign sel_half = line_word[half_off +: 16];

    // Lane select and extension of the cached word for load hits
    always_comb begin
        load_ext = '0;
        case (modeAddr)
            3'b001:  load_ext = line_word;
            3'b010:  load_ext = {{(WIDTH-16){sel_half[15]}}, sel_half};
            3'b011:  load_ext = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {{(WIDTH-16){1'b0}}, sel_half};
            3'b101:  load_ext = {{(WIDTH-8){1'b0}}, sel_byte};
            default: load_ext = '0;
        endcase
    end

    // Merge store data into the addressed lanes of the resident word
    always_comb begin
        store_word = line_word;
        if (mode_word) begin
            store_word = WD;
        end else if (mode_half) begin
            store_word[half_off +: 16] = WD[15:0];
        end else if (mode_byte) begin
            store_word[byte_off +: 8] = WD[7:0];
        end
    end

    // FSM state and miss-wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state, stall and memory-side routing
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        stall        = 1'b0;
        mem_A        = A;
        mem_modeAddr = modeAddr;
        mem_WD       = WD;
        mem_WE       = 1'b0;
        RD           = '0;
        fill_en      = 1'b0;
        case (state)
            S_IDLE: begin
                // Every store, cached or not, is written through in this cycle
                mem_WE = MemWrite;
                if (bypass) begin
                    if (is_load) begin
                        RD = mem_RD;
                    end
                end else if (cache_load) begin
                    if (line_hit) begin
                        RD = load_ext;
                    end else begin
                        stall   = 1'b1;
                        state_n = S_MISS;
                        cnt_n   = CW'(1);
                    end
                end
            end
            S_MISS: begin
                stall = 1'b1;
                if (cnt == CW'(MISS_CYCLES)) begin
                    state_n = S_FILL;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_FILL: begin
                stall        = 1'b1;
                mem_A        = {A[WIDTH-1:2], 2'b00};
                mem_modeAddr = 3'b001;
                fill_en      = 1'b1;
                state_n      = S_IDLE;
                cnt_n        = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Valid bits: reset/flush clear all, fill sets, misaligned store drops its line
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[idx] <= 1'b1;
        end else if (state == S_IDLE && MemWrite && misaligned) begin
            valid[idx] <= 1'b0;
        end
    end

    // Tag and data arrays: fill from memory, or merge a store hit
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_en) begin
                tag_mem[idx]  <= tag_in;
                data_mem[idx] <= mem_RD;
            end else if (state == S_IDLE && cache_store && line_hit) begin
                data_mem[idx] <= store_word;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic just_filled;
    logic hit_acc;
    logic miss_start;

    // The cycle right after a fill completes a miss, not a fresh hit
    assign hit_acc    = (state == S_IDLE) && cache_load && line_hit && !just_filled;
    assign miss_start = (state == S_IDLE) && cache_load && !line_hit;

    // Marks the IDLE cycle that follows FILL
    always_ff @(posedge clk) begin
        if (rst) begin
            just_filled <= 1'b0;
        end else begin
            just_filled <= (state == S_FILL);
        end
    end

    // Saturating hit/miss counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_acc && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - directed self-checking bench for dcache_direct
module tb_dcache_direct;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  modeAddr;
    logic [31:0] A;
    logic [31:0] WD;
    logic        flush;
    logic [31:0] RD;
    logic        stall;
    logic [2:0]  mem_modeAddr;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks;
    int n_fail;
    logic        load_mem;
    logic [31:0] mem [256];

    dcache_direct dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .modeAddr     (modeAddr),
        .A            (A),
        .WD           (WD),
        .flush        (flush),
        .RD           (RD),
        .stall        (stall),
        .mem_modeAddr (mem_modeAddr),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_WE       (mem_WE),
        .mem_RD       (mem_RD)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-returning backing store; stores merge by mode at the edge
    assign mem_RD = mem[mem_A[9:2]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h20] <= 32'h11223344;
            mem[8'h40] <= 32'h00000001;
            mem[8'h50] <= 32'hCAFEF00D;
        end else if (mem_WE) begin
            case (mem_modeAddr)
                3'b001:         mem[mem_A[9:2]] <= mem_WD;
                3'b010, 3'b100: mem[mem_A[9:2]][{mem_A[1], 4'b0000} +: 16] <= mem_WD[15:0];
                3'b011, 3'b101: mem[mem_A[9:2]][{mem_A[1:0], 3'b000} +: 8] <= mem_WD[7:0];
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] md,
                         input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        modeAddr = md;
        A        = ad;
        WD       = wd;
        #1;
    endtask

    task automatic do_load(input logic [31:0] ad, input logic [2:0] md,
                           output int ns, output logic [31:0] rdv);
        drive(1'b1, 1'b0, md, ad, 32'h0);
        ns = 0;
        while (stall && ns < 20) begin
            ns++;
            @(negedge clk);
            #1;
        end
        rdv = RD;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    int          ns;
    logic [31:0] rdv;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        load_mem = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        modeAddr = 3'b001;
        A        = 32'h0;
        WD       = 32'h0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        load_mem = 1'b0;
        #1;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_we", {31'b0, mem_WE}, 32'd0);
        check("reset_rd", RD, 32'h0);

        // Cold miss then hit
        do_load(32'h40, 3'b001, ns, rdv);
        check("miss_stall_cycles", ns, 32'd4);
        check("miss_rd", rdv, 32'hDEADBEEF);
        do_load(32'h40, 3'b001, ns, rdv);
        check("hit_stall", ns, 32'd0);
        check("hit_rd", rdv, 32'hDEADBEEF);
        check("hit_mem_a", mem_A, 32'h40);

        // Sub-word extraction
        do_load(32'h43, 3'b011, ns, rdv);
        check("lb_rd", rdv, 32'hFFFFFFDE);
        check("lb_stall", ns, 32'd0);
        do_load(32'h43, 3'b101, ns, rdv);
        check("lbu_rd", rdv, 32'h000000DE);
        do_load(32'h40, 3'b010, ns, rdv);
        check("lh_rd", rdv, 32'hFFFFBEEF);

        // Store hit, write-through
        drive(1'b0, 1'b1, 3'b011, 32'h41, 32'h12);
        check("sb_we", {31'b0, mem_WE}, 32'd1);
        check("sb_mode", {29'b0, mem_modeAddr}, 32'd3);
        check("sb_stall", {31'b0, stall}, 32'd0);
        do_load(32'h40, 3'b001, ns, rdv);
        check("after_sb_rd", rdv, 32'hDEAD12EF);
        check("after_sb_stall", ns, 32'd0);

        // Bypass paths
        do_load(32'h100, 3'b001, ns, rdv);
        check("mmio_stall", ns, 32'd0);
        check("mmio_rd", rdv, 32'h00000001);
        do_load(32'h42, 3'b001, ns, rdv);
        check("mis_stall", ns, 32'd0);
        check("mis_mem_a", mem_A, 32'h42);
        check("mis_rd", rdv, 32'hDEAD12EF);

        // Undefined load mode
        do_load(32'h40, 3'b000, ns, rdv);
        check("undef_stall", ns, 32'd0);
        check("undef_rd", rdv, 32'h0);

        // Reset while in MISS
        drive(1'b1, 1'b0, 3'b001, 32'h80, 32'h0);
        check("rmiss_detect", {31'b0, stall}, 32'd1);
        @(negedge clk);
        #1;
        check("rmiss_in_miss", {31'b0, stall}, 32'd1);
        do_reset();
        check("rmiss_stall_after", {31'b0, stall}, 32'd0);
        do_load(32'h40, 3'b001, ns, rdv);
        check("post_rst_stall", ns, 32'd4);
        check("post_rst_rd", rdv, 32'hDEAD12EF);

        // Flush after fill
        @(negedge clk);
        MemRead = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        do_load(32'h40, 3'b001, ns, rdv);
        check("post_flush_stall", ns, 32'd4);

        // Misaligned store invalidates its line
        drive(1'b0, 1'b1, 3'b001, 32'h42, 32'hDEAD12EF);
        check("mis_st_we", {31'b0, mem_WE}, 32'd1);
        check("mis_st_a", mem_A, 32'h42);
        do_load(32'h40, 3'b001, ns, rdv);
        check("mis_st_refill", ns, 32'd4);

        // Conflicting addresses on one index
        do_reset();
        do_load(32'h40, 3'b001, ns, rdv);
        check("alt0_stall", ns, 32'd4);
        check("alt0_rd", rdv, 32'hDEAD12EF);
        do_load(32'h140, 3'b001, ns, rdv);
        check("alt1_stall", ns, 32'd4);
        check("alt1_rd", rdv, 32'hCAFEF00D);
        do_load(32'h40, 3'b001, ns, rdv);
        check("alt2_stall", ns, 32'd4);
        do_load(32'h140, 3'b001, ns, rdv);
        check("alt3_stall", ns, 32'd4);
        check("alt3_rd", rdv, 32'hCAFEF00D);
`ifdef DCACHE_STATS_EN
        check("stat_miss", miss_count, 32'd4);
        check("stat_hit0", hit_count, 32'd0);
        do_load(32'h140, 3'b001, ns, rdv);
        check("stat_hit_stall", ns, 32'd0);
        drive(1'b0, 1'b0, 3'b001, 32'h0, 32'h0);
        check("stat_hit1", hit_count, 32'd1);
        check("stat_miss_hold", miss_count, 32'd4);
`endif

        drive(1'b0, 1'b0, 3'b001, 32'h0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
